// File: rtl/edge_seq_ctrl.sv
// Beat packer and raster window sequencer for the edge engine (border bypass when EDGE_SEQ_SKIP_BORDER_EN is defined).
// Latency: buffer write 1 cycle after the beat; result 1 cycle after edge_valid; done 1 cycle after the last result.
// Backpressure: holds win_req/win_row/win_col until win_ack; exactly one request outstanding; input beats are never stalled.
module edge_seq_ctrl #(
    parameter int IMG_W = 20,
    parameter int IMG_H = 20,
    parameter int PIX_W = 5,
    parameter int LANES = 5,
    localparam int NBEATS = IMG_W * IMG_H / LANES,
    localparam int AW = $clog2(NBEATS),
    localparam int RW = $clog2(IMG_H),
    localparam int CW = $clog2(IMG_W)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    input  logic [PIX_W-1:0]       pixel_in0,
    input  logic [PIX_W-1:0]       pixel_in1,
    input  logic [PIX_W-1:0]       pixel_in2,
    input  logic [PIX_W-1:0]       pixel_in3,
    input  logic [PIX_W-1:0]       pixel_in4,
    input  logic                   load_end,
    output logic                   buf_wen,
    output logic [AW-1:0]          buf_waddr,
    output logic [LANES*PIX_W-1:0] buf_wdata,
    output logic                   win_req,
    output logic [RW-1:0]          win_row,
    output logic [CW-1:0]          win_col,
    input  logic                   win_ack,
    input  logic                   edge_valid,
    input  logic                   edge_bit,
    output logic                   edge_out,
    output logic                   readable,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT, FIN} state_t;

    state_t                   state, state_nxt;
    logic [AW:0]              bc;
    logic [RW-1:0]            row;
    logic [CW-1:0]            col;
    logic                     last_pix;
    logic                     accept;
    logic                     adv;
    logic                     res_bit;
    logic [LANES*PIX_W-1:0]   beat_dat;

    assign beat_dat = {pixel_in4, pixel_in3, pixel_in2, pixel_in1, pixel_in0};
    assign last_pix = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));
    assign accept   = in_valid && ((state == IDLE) || (state == LOAD));

`ifdef EDGE_SEQ_SKIP_BORDER_EN
    logic border;
    assign border  = (row == '0) || (row == RW'(IMG_H - 1)) ||
                     (col == '0) || (col == CW'(IMG_W - 1));
    // Border pixels are answered locally with a zero result, one per cycle.
    assign adv     = ((state == WAIT) && edge_valid) || ((state == REQ) && border);
    assign res_bit = (state == WAIT) ? edge_bit : 1'b0;
`else
    assign adv     = (state == WAIT) && edge_valid;
    assign res_bit = edge_bit;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = load_end ? REQ : LOAD;
            LOAD: if (in_valid && load_end) state_nxt = REQ;
            REQ: begin
`ifdef EDGE_SEQ_SKIP_BORDER_EN
                if (border)       state_nxt = last_pix ? FIN : REQ;
                else if (win_ack) state_nxt = WAIT;
`else
                if (win_ack) state_nxt = WAIT;
`endif
            end
            WAIT: if (edge_valid) state_nxt = last_pix ? FIN : REQ;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        win_req = (state == REQ);
`ifdef EDGE_SEQ_SKIP_BORDER_EN
        win_req = (state == REQ) && !border;
`endif
        win_row = row;
        win_col = col;
        // done is registered off FIN, so busy is stretched to cover it.
        busy    = (state != IDLE) || done;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_wen   <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
            bc        <= '0;
            row       <= '0;
            col       <= '0;
            edge_out  <= 1'b0;
            readable  <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            buf_wen  <= 1'b0;
            readable <= 1'b0;
            done     <= (state == FIN);
            if (accept) begin
                if (state == IDLE) begin
                    buf_wen   <= 1'b1;
                    buf_waddr <= '0;
                    buf_wdata <= beat_dat;
                    bc        <= (AW+1)'(1);
                end else if (bc < (AW+1)'(NBEATS)) begin
                    buf_wen   <= 1'b1;
                    buf_waddr <= bc[AW-1:0];
                    buf_wdata <= beat_dat;
                    bc        <= bc + (AW+1)'(1);
                end else begin
                    ovf <= 1'b1;
                end
            end
            if (adv) begin
                readable <= 1'b1;
                edge_out <= res_bit;
                if (col == CW'(IMG_W - 1)) begin
                    col <= '0;
                    row <= last_pix ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_seq_ctrl.sv
// Directed bench for edge_seq_ctrl: frame load, raster sequencing, overflow, stalls and reset.
`timescale 1ns/1ps
module tb_edge_seq_ctrl;
    localparam int IMG_W = 20, IMG_H = 20, PIX_W = 5, LANES = 5;
    localparam int NB   = IMG_W * IMG_H / LANES;
    localparam int NPIX = IMG_W * IMG_H;
    localparam int AW = $clog2(NB), RW = $clog2(IMG_H), CW = $clog2(IMG_W);
`ifdef EDGE_SEQ_SKIP_BORDER_EN
    localparam int EXP_REQ = (IMG_W - 2) * (IMG_H - 2);
`else
    localparam int EXP_REQ = NPIX;
`endif

    logic clk = 1'b0;
    logic reset_n, in_valid, load_end, win_ack, edge_valid, edge_bit;
    logic [PIX_W-1:0] pixel_in0, pixel_in1, pixel_in2, pixel_in3, pixel_in4;
    logic buf_wen, win_req, edge_out, readable, busy, done, ovf;
    logic [AW-1:0] buf_waddr;
    logic [LANES*PIX_W-1:0] buf_wdata;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    edge_seq_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .LANES(LANES)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .pixel_in0(pixel_in0), .pixel_in1(pixel_in1), .pixel_in2(pixel_in2),
        .pixel_in3(pixel_in3), .pixel_in4(pixel_in4), .load_end(load_end),
        .buf_wen(buf_wen), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
        .win_req(win_req), .win_row(win_row), .win_col(win_col), .win_ack(win_ack),
        .edge_valid(edge_valid), .edge_bit(edge_bit), .edge_out(edge_out),
        .readable(readable), .busy(busy), .done(done), .ovf(ovf)
    );

    function automatic logic [LANES*PIX_W-1:0] beat_data(input int k);
        logic [LANES*PIX_W-1:0] d;
        d = '0;
        for (int i = 0; i < LANES; i++) d[i*PIX_W +: PIX_W] = PIX_W'(k * LANES + i);
        return d;
    endfunction

    // Engine answers row[0]; border positions are zero when bypassed.
    function automatic logic exp_edge(input int idx);
        int r, c;
        r = idx / IMG_W;
        c = idx % IMG_W;
`ifdef EDGE_SEQ_SKIP_BORDER_EN
        if (r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1) return 1'b0;
`endif
        return r[0];
    endfunction

    task automatic clear_inputs();
        in_valid = 0; load_end = 0; win_ack = 0; edge_valid = 0; edge_bit = 0;
        pixel_in0 = 0; pixel_in1 = 0; pixel_in2 = 0; pixel_in3 = 0; pixel_in4 = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_n = 0;
        repeat (2) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic run_frame(input string tag, input int nbeats, input int end_idx,
                             input int ack_dly, input int res_dly, input int abort_idx);
        int beat, wr_cnt, rd_cnt, req_cnt, done_cnt, cyc, last_rd, req_wait, res_cnt, post;
        bit outstanding, le_check, started, finished, aborting;
        logic [RW-1:0] hold_row;
        logic [CW-1:0] hold_col;
        logic [LANES*PIX_W-1:0] d;
        beat = 0; wr_cnt = 0; rd_cnt = 0; req_cnt = 0; done_cnt = 0; cyc = 0;
        last_rd = -10; req_wait = 0; res_cnt = 0; post = 0;
        outstanding = 0; le_check = 0; started = 0; finished = 0; aborting = 0;
        hold_row = '0; hold_col = '0;
        while (!finished && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (aborting) begin
                clear_inputs();
                finished = 1;
            end else begin
                if (buf_wen === 1'b1) begin
                    d = beat_data(wr_cnt);
                    checks++;
                    if (wr_cnt >= NB || buf_waddr !== AW'(wr_cnt) || buf_wdata !== d) begin
                        errors++;
                        $display("FAIL %s write#%0d: addr=%0d data=%h, required addr=%0d data=%h",
                                 tag, wr_cnt, buf_waddr, buf_wdata, wr_cnt, d);
                    end
                    wr_cnt++;
                end
                if (started) begin
                    checks++;
                    if (ovf !== (beat > NB)) begin
                        errors++;
                        $display("FAIL %s ovf after %0d beats: got %b, required %b", tag, beat, ovf, beat > NB);
                    end
                end
                if (le_check) begin
                    checks++;
                    if (win_req !== 1'b1) begin
                        errors++;
                        $display("FAIL %s win_req after load_end: got %b, required 1", tag, win_req);
                    end
                end
                le_check = 0;
                if (started && done_cnt == 0) begin
                    checks++;
                    if (busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s busy cycle %0d: got %b, required 1", tag, cyc, busy);
                    end
                end
                if (readable === 1'b1) begin
                    checks++;
                    if (rd_cnt >= NPIX || edge_out !== exp_edge(rd_cnt)) begin
                        errors++;
                        $display("FAIL %s result#%0d: edge_out=%b, required %b", tag, rd_cnt, edge_out, exp_edge(rd_cnt));
                    end
                    rd_cnt++;
                    last_rd = cyc;
                end
                if (done === 1'b1) begin
                    checks++;
                    if (rd_cnt != NPIX || cyc != last_rd + 1 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL %s done: results=%0d gap=%0d busy=%b, required results=%0d gap=1 busy=1",
                                 tag, rd_cnt, cyc - last_rd, busy, NPIX);
                    end
                    done_cnt++;
                end
                if (done_cnt > 0) begin
                    post++;
                    if (post > 3) finished = 1;
                end
                win_ack = 0; edge_valid = 0; edge_bit = 0;
                if (win_req === 1'b1) begin
                    checks++;
                    if (outstanding) begin
                        errors++;
                        $display("FAIL %s second request while outstanding at result#%0d", tag, rd_cnt);
                    end
                    if (req_wait == 0) begin
                        checks++;
                        if (win_row !== RW'(rd_cnt / IMG_W) || win_col !== CW'(rd_cnt % IMG_W)) begin
                            errors++;
                            $display("FAIL %s request position: (%0d,%0d), required (%0d,%0d)",
                                     tag, win_row, win_col, rd_cnt / IMG_W, rd_cnt % IMG_W);
                        end
                        hold_row = win_row;
                        hold_col = win_col;
                        req_cnt++;
                    end else begin
                        checks++;
                        if (win_row !== hold_row || win_col !== hold_col) begin
                            errors++;
                            $display("FAIL %s request unstable: (%0d,%0d), required (%0d,%0d)",
                                     tag, win_row, win_col, hold_row, hold_col);
                        end
                    end
                    if (req_wait >= ack_dly) begin
                        win_ack = 1;
                        outstanding = 1;
                        res_cnt = 0;
                        req_wait = 0;
                        if (rd_cnt == abort_idx) aborting = 1;
                    end else begin
                        req_wait++;
                    end
                end else if (outstanding) begin
                    res_cnt++;
                    if (res_cnt >= res_dly) begin
                        edge_valid = 1;
                        edge_bit = hold_row[0];
                        outstanding = 0;
                    end
                end
                if (beat < nbeats) begin
                    d = beat_data(beat);
                    in_valid = 1;
                    pixel_in0 = d[0*PIX_W +: PIX_W];
                    pixel_in1 = d[1*PIX_W +: PIX_W];
                    pixel_in2 = d[2*PIX_W +: PIX_W];
                    pixel_in3 = d[3*PIX_W +: PIX_W];
                    pixel_in4 = d[4*PIX_W +: PIX_W];
                    load_end = (beat == end_idx);
                    if (beat == end_idx) le_check = 1;
                    beat++;
                    started = 1;
                end else begin
                    in_valid = 0;
                    load_end = 0;
                end
            end
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL %s timeout: results=%0d, required %0d before cycle budget", tag, rd_cnt, NPIX);
        end
        if (abort_idx < 0) begin
            checks++;
            if (wr_cnt != ((nbeats < NB) ? nbeats : NB) || rd_cnt != NPIX ||
                req_cnt != EXP_REQ || done_cnt != 1) begin
                errors++;
                $display("FAIL %s totals: writes=%0d results=%0d requests=%0d done=%0d, required %0d %0d %0d 1",
                         tag, wr_cnt, rd_cnt, req_cnt, done_cnt,
                         (nbeats < NB) ? nbeats : NB, NPIX, EXP_REQ);
            end
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        @(negedge clk);
        checks++;
        if ({buf_wen, buf_waddr, buf_wdata, win_req, win_row, win_col,
             edge_out, readable, busy, done, ovf} !== '0) begin
            errors++;
            $display("FAIL reset outputs: not all zero (busy=%b ovf=%b wen=%b req=%b)", busy, ovf, buf_wen, win_req);
        end
        reset_n = 1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || buf_wen !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b wen=%b, required 0 0", busy, buf_wen);
        end
    endtask

    task automatic test_full_frame();
        do_reset();
        run_frame("full", NB, NB - 1, 0, 1, -1);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b", NB, NB - 1, 0, 1, -1);
    endtask

    task automatic test_overflow();
        do_reset();
        run_frame("ovf", NB + 2, NB + 1, 0, 1, -1);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got %b, required 1", ovf);
        end
    endtask

    task automatic test_short_load();
        do_reset();
        run_frame("short", 11, 10, 0, 1, -1);
    endtask

    task automatic test_stalled_engine();
        do_reset();
        run_frame("stall", NB, NB - 1, 3, 4, -1);
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        run_frame("abort", 3, 2, 0, 1, 7 * IMG_W + 3);
        checks++;
        if (busy !== 1'b1 || win_req !== 1'b0 || win_row !== RW'(7) || win_col !== CW'(3)) begin
            errors++;
            $display("FAIL mid_wait: busy=%b req=%b pos=(%0d,%0d), required 1 0 (7,3)", busy, win_req, win_row, win_col);
        end
        reset_n = 0;
        #1;
        checks++;
        if ({buf_wen, buf_waddr, buf_wdata, win_req, win_row, win_col,
             edge_out, readable, busy, done, ovf} !== '0) begin
            errors++;
            $display("FAIL async_reset: outputs not zero (busy=%b row=%0d col=%0d)", busy, win_row, win_col);
        end
        @(negedge clk);
        reset_n = 1;
        run_frame("restart", 4, 3, 0, 1, -1);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_back_to_back();
        test_overflow();
        test_short_load();
        test_stalled_engine();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/edge_seq_ctrl.md
# edge_seq_ctrl

Sequencer between the 5-lane pixel input port and the edge-detection datapath of the edge-detection chip. It packs incoming 5-pixel beats into the image buffer. After `load_end` it walks every pixel position in raster order and issues one window request per pixel to the edge engine. Each returned edge bit is forwarded serially on `edge_out` with a `readable` strobe, and `done` pulses when the frame is finished.

## Interface
- `IMG_W`, 20: image width in pixels; must be a multiple of `LANES`.
- `IMG_H`, 20: image height in pixels.
- `PIX_W`, 5: bits per pixel.
- `LANES`, 5: pixels per input beat.

Derived widths: `AW = $clog2(IMG_W*IMG_H/LANES)`, `RW = $clog2(IMG_H)`, `CW = $clog2(IMG_W)`.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat present on `pixel_in0..4`.
- `pixel_in0` .. `pixel_in4`  in  `PIX_W` each  beat lanes; lane 0 is the leftmost pixel.
- `load_end`  in  1  qualified by `in_valid`; marks the last beat of the frame.
- `buf_wen`  out  1  image-buffer write strobe.
- `buf_waddr`  out  AW  beat address.
- `buf_wdata`  out  `LANES*PIX_W`  {lane4,…,lane0}.
- `win_req`  out  1  window request to the edge engine.
- `win_row`  out  RW  window centre row.
- `win_col`  out  CW  window centre column.
- `win_ack`  in  1  engine accepted the request.
- `edge_valid`  in  1  engine result valid.
- `edge_bit`  in  1  engine result.
- `edge_out`  out  1  registered result bit.
- `readable`  out  1  `edge_out` valid this cycle.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle end-of-frame pulse.
- `ovf`  out  1  sticky flag: beats beyond the frame were dropped.

## Operation
- States: IDLE, LOAD, REQ, WAIT, FIN.
- **IDLE**
  - `in_valid` = 1: write the beat at address 0, then go to LOAD.
  - If `load_end` is also 1, go straight to REQ.
- **LOAD**
  - Each `in_valid` beat is written at beat counter `bc`, then `bc` increments.
  - `load_end` with `in_valid` goes to REQ.
  - Beats with `bc` ≥ `IMG_W*IMG_H/LANES` are not written and set `ovf`. `bc` saturates and does not wrap.
  - `load_end` before a full frame also goes to REQ. Unwritten buffer words keep their old contents; no error is flagged.
  - `in_valid` = 0 cycles are idle and do not advance `bc`.
- **Buffer write**
  - `buf_wen`, `buf_waddr` and `buf_wdata` are registered and appear one cycle after the accepted beat.
  - Beat n covers pixels n·LANES … n·LANES+LANES−1 of the row-major image.
- **REQ**
  - Drive `win_req` = 1 with `win_row` and `win_col` = the current raster position; hold them stable until `win_ack`.
  - On `win_ack`, go to WAIT and deassert `win_req` on the next cycle.
- **WAIT**
  - Exactly one request is outstanding.
  - On `edge_valid`: register `edge_out` = `edge_bit` and pulse `readable` = 1 on the next cycle.
  - Then advance: col++; at col = IMG_W−1 wrap col to 0 and row++.
  - After the result for (IMG_H−1, IMG_W−1), go to FIN; otherwise go to REQ.
- **FIN**
  - `done` = 1 for one cycle, then go to IDLE. `ovf` stays set.
- `in_valid` and `load_end` are ignored in REQ, WAIT and FIN.
- `edge_valid` outside WAIT is ignored.
- **Reset**
  - Asserting `reset_n` = 0 at any time, including mid-load or mid-processing, forces IDLE and clears `bc`, row, col and `ovf`.
  - All outputs go to 0: `buf_wen`, `buf_waddr`, `buf_wdata`, `win_req`, `win_row`, `win_col`, `edge_out`, `readable`, `busy`, `done`, `ovf`.

## Timing
- Accepted beat at edge t → `buf_wen` high in cycle t+1.
- `load_end` beat at edge t → state REQ after edge t, `win_req` high in cycle t+1.
  - The last buffer write (cycle t+1) coincides with the first `win_req`. The buffer is write-first.
- `win_ack` in the same cycle as `win_req` is legal; minimum REQ dwell is one cycle.
- `edge_valid` at edge t → `readable` and `edge_out` in cycle t+1.
  - The next `win_req` is also asserted in cycle t+1.
  - Minimum per-pixel period: 2 cycles with zero-latency ack and result.
- `edge_valid` may arrive one or more cycles after `win_ack`. `edge_valid` coincident with `win_ack` is illegal.
- `done` is asserted in the cycle after the last `readable`.
- `busy` = 1 from the cycle after the first accepted beat until the cycle `done` is asserted, inclusive.

## Configuration
- `EDGE_SEQ_SKIP_BORDER_EN` defined:
  - Positions with row ∈ {0, IMG_H−1} or col ∈ {0, IMG_W−1} are not requested from the engine.
  - For each such position the controller emits `edge_out` = 0 with `readable` = 1 directly, one per cycle, in raster order.
  - Interior pixels are sequenced normally.
- Not defined: every pixel is requested from the engine; no bypass logic exists.

## Test plan
- **Full frame, default params**
  - Stimulus: 80 beats with pixel value = k[4:0] per lane; `load_end` on beat 79; engine acks immediately and returns `edge_bit` = row[0] one cycle later.
  - Response: buffer addresses 0..79 written; 400 `readable` pulses with matching bits; one `done` pulse; `ovf` = 0.
- **Overflow**
  - Stimulus: 82 beats, `load_end` on beat 81.
  - Response: only addresses 0..79 written; `ovf` = 1 after beat 80; 400 results.
- **Short load**
  - Stimulus: `load_end` on beat 10.
  - Response: `win_req` in the cycle after the `load_end` beat; processing still covers all 400 positions.
- **Stalled engine**
  - Stimulus: `win_ack` delayed 3 cycles and `edge_valid` delayed 4 cycles.
  - Response: `win_row`/`win_col` stable while `win_req` is high; no second request while one is outstanding.
- **Reset mid-WAIT at pixel (7,3)**
  - Response: all outputs 0 immediately; the next frame restarts at address 0 and position (0,0).
- **With `EDGE_SEQ_SKIP_BORDER_EN`**
  - Response: 324 engine requests and 76 direct zero outputs; 400 `readable` pulses in raster order.
